hps_reset_seq: RTL and testbench
================================

HPS_RESET_SEQ -- requirements
Module: hps_reset_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, named clk_clk and reset_reset_n.
REQ-002 Parameter NUM_SRC SHALL default to 4 and give the number of reset-request sources (range 1..16).
REQ-003 Parameter SRC_KIND SHALL default to 8'b11_10_01_00 and hold 2 bits per source: 0 = cold, 1 = warm, 2 = debug, 3 = disabled.
REQ-004 Parameter DEBOUNCE_CYCLES SHALL default to 1000 and give the stable-high cycles required per source (minimum 1).
REQ-005 Parameter PULSE_CYCLES SHALL default to 16 and give the asserted width of an f2h request (minimum 1).
REQ-006 Parameter HOLDOFF_CYCLES SHALL default to 64 and give the quiet cycles after a pulse (minimum 1).
REQ-007 Parameter RELEASE_DELAY SHALL default to 8 and give the fabric reset deassert delay (minimum 1).
REQ-008 Parameter CNT_W SHALL default to 8 and give the width of req_count.
REQ-009 Port clk_clk SHALL be an input, 1 bit: system clock.
REQ-010 Port reset_reset_n SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-011 Port src_req SHALL be an input, NUM_SRC bits, asynchronous and active-high: one request per source.
REQ-012 Port h2f_reset_n SHALL be an input, 1 bit, asynchronous: the HPS-to-fabric reset.
REQ-013 Port f2h_cold_reset_req_n SHALL be an output, 1 bit, active-low: cold request to the HPS.
REQ-014 Port f2h_warm_reset_req_n SHALL be an output, 1 bit, active-low: warm request to the HPS.
REQ-015 Port f2h_debug_reset_req_n SHALL be an output, 1 bit, active-low: debug request to the HPS.
REQ-016 Port fabric_rst_n SHALL be an output, 1 bit, active-low: synchronised fabric reset.
REQ-017 Port busy SHALL be an output, 1 bit, high whenever the FSM is not in IDLE.
REQ-018 Port last_kind SHALL be an output, 2 bits, holding the kind of the most recent issued pulse.
REQ-019 Port req_count SHALL be an output, CNT_W bits, counting issued pulses and saturating at its maximum.

Function
REQ-020 Each src_req bit SHALL pass through a 2-flop synchroniser, then a per-source debounce counter.
REQ-021 The debounced level SHALL rise after DEBOUNCE_CYCLES consecutive synchronised-high cycles and fall on the first synchronised-low cycle.
REQ-022 A source event SHALL be the rising edge of its debounced level; sources of kind 3 SHALL never produce events.
REQ-023 The FSM SHALL have three states: IDLE, PULSE and HOLDOFF.
REQ-024 In IDLE, when any event or pending kind exists, the FSM SHALL enter PULSE next cycle with the highest-priority kind (cold > warm > debug).
REQ-025 In PULSE, exactly the selected f2h_*_req_n SHALL be low for PULSE_CYCLES cycles; the FSM SHALL then enter HOLDOFF.
REQ-026 In HOLDOFF, all request outputs SHALL be high for HOLDOFF_CYCLES cycles; the FSM SHALL then return to IDLE.
REQ-027 Events occurring in PULSE or HOLDOFF SHALL be OR-ed into a 3-bit pending register.
REQ-028 Issuing kind K SHALL clear pending K and every lower-priority pending kind; simultaneous lower-priority events in that same cycle SHALL be discarded.
REQ-029 When the FSM enters PULSE, last_kind SHALL load K and req_count SHALL increment unless it is at 2^CNT_W-1.
REQ-030 Request latency SHALL be as follows: the output goes low on clock edge 3+DEBOUNCE_CYCLES, counting the first edge sampling src_req high as edge 1.
REQ-031 h2f_reset_n SHALL be 2-flop synchronised; fabric_rst_n SHALL go low on the cycle the synchronised value is low.
REQ-032 fabric_rst_n SHALL go high only after RELEASE_DELAY consecutive synchronised-high cycles; any low restarts the delay.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 While reset_reset_n is low, the block SHALL drive all f2h_*_req_n = 1, fabric_rst_n = 0, busy = 0, last_kind = 0 and req_count = 0.
REQ-035 While reset_reset_n is low, the FSM SHALL be in IDLE and all synchronisers, debounce counters and pending bits SHALL be 0.
REQ-036 Reset asserted mid-PULSE SHALL deassert the request output immediately (asynchronously), with no resumption after reset release.

Verification (NUM_SRC=4, default SRC_KIND, DEBOUNCE=4, PULSE=3, HOLDOFF=5, RELEASE=2, CNT_W=2)
REQ-037 src_req[0] held high -> f2h_cold_reset_req_n low on edge 7 for exactly 3 cycles, then busy low 5 cycles later, last_kind=0, req_count=1.
REQ-038 src_req[0] high for only 3 cycles, and src_req[3] held high -> no request output ever goes low and req_count stays 0.
REQ-039 src_req[1] and src_req[2] rise together -> a warm pulse only, and the debug event is discarded.
REQ-040 Warm pulse active when a cold event arrives -> warm completes, holdoff, then a 3-cycle cold pulse with last_kind=0.
REQ-041 Five sequential cold pulses -> req_count saturates at 3.
REQ-042 h2f_reset_n low then high -> fabric_rst_n low within 3 edges and high 2 cycles after sync-high; reset_reset_n pulsed low mid-PULSE -> outputs return to reset values (REQ-034) immediately.

Source files
------------

// File: rtl/hps_reset_seq.sv
// ---------------------------------------------------------------------------
// hps_reset_seq
//   Turns asynchronous fabric reset-request lines into clean, rate-limited
//   cold/warm/debug request pulses towards the HPS. It also produces a
//   synchronised fabric reset from the HPS-to-fabric reset.
//
//   Each source is synchronised and then debounced. The rising edge of a
//   debounced level is an event of that source's kind. A three-state FSM
//   (IDLE -> PULSE -> HOLDOFF) issues one active-low pulse at a time. It picks
//   the highest-priority kind (cold > warm > debug). Events that arrive while
//   the FSM is busy are remembered in a pending register.
//
// Ports
//   clk_clk               in   system clock
//   reset_reset_n         in   asynchronous active-low reset
//   src_req[NUM_SRC]      in   asynchronous active-high reset requests
//   h2f_reset_n           in   asynchronous HPS-to-fabric reset
//   f2h_cold_reset_req_n  out  cold request to the HPS, active-low
//   f2h_warm_reset_req_n  out  warm request to the HPS, active-low
//   f2h_debug_reset_req_n out  debug request to the HPS, active-low
//   fabric_rst_n          out  synchronised fabric reset, active-low
//   busy                  out  FSM is outside IDLE
//   last_kind[2]          out  kind of the most recently issued pulse
//   req_count[CNT_W]      out  saturating count of issued pulses
// ---------------------------------------------------------------------------
module hps_reset_seq #(
  parameter int                   NUM_SRC         = 4,
  parameter logic [2*NUM_SRC-1:0] SRC_KIND        = 8'b11_10_01_00,
  parameter int                   DEBOUNCE_CYCLES = 1000,
  parameter int                   PULSE_CYCLES    = 16,
  parameter int                   HOLDOFF_CYCLES  = 64,
  parameter int                   RELEASE_DELAY   = 8,
  parameter int                   CNT_W           = 8
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic [NUM_SRC-1:0] src_req,
  input  logic               h2f_reset_n,
  output logic               f2h_cold_reset_req_n,
  output logic               f2h_warm_reset_req_n,
  output logic               f2h_debug_reset_req_n,
  output logic               fabric_rst_n,
  output logic               busy,
  output logic [1:0]         last_kind,
  output logic [CNT_W-1:0]   req_count
);

  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMR_MAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int REL_W   = $clog2(RELEASE_DELAY + 1);

  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLDOFF_CYCLES - 1);
  localparam logic [REL_W-1:0] REL_LAST   = REL_W'(RELEASE_DELAY - 1);

  localparam logic [1:0] KIND_COLD  = 2'd0;
  localparam logic [1:0] KIND_WARM  = 2'd1;
  localparam logic [1:0] KIND_DEBUG = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_HOLDOFF} state_e;

  // -------------------------------------------------------------------------
  // Source synchronisers and debouncers
  // -------------------------------------------------------------------------
  logic [NUM_SRC-1:0] src_s1_q, src_s2_q;
  logic [NUM_SRC-1:0] deb_q, deb_prev_q;
  logic [DEB_W-1:0]   deb_cnt_q [NUM_SRC];

  // NOTE: clocked state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      src_s1_q   <= '0;
      src_s2_q   <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      // NOTE: this counter array is plain flops, not a RAM, so it is reset
      // element by element like any other register.
      for (int i = 0; i < NUM_SRC; i++) deb_cnt_q[i] <= '0;
    end else begin
      src_s1_q   <= src_req;
      src_s2_q   <= src_s1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!src_s2_q[i]) begin
          // A single low sample drops the level and restarts the count.
          deb_cnt_q[i] <= '0;
          deb_q[i]     <= 1'b0;
        end else if (!deb_q[i]) begin
          if (deb_cnt_q[i] == DEB_LAST) deb_q[i] <= 1'b1;
          else                          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Rising debounced edges, folded into one bit per kind (index = kind).
  // Disabled sources (kind 3) never produce an event.
  logic [2:0] kind_evt;

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    kind_evt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (deb_q[i] && !deb_prev_q[i]) begin
        case (SRC_KIND[2*i +: 2])
          KIND_COLD:  kind_evt[0] = 1'b1;
          KIND_WARM:  kind_evt[1] = 1'b1;
          KIND_DEBUG: kind_evt[2] = 1'b1;
          default:    ;
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Request FSM
  // -------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [2:0]         pend_q, pend_d;
  logic [1:0]         last_kind_q, last_kind_d;
  logic [CNT_W-1:0]   req_count_q, req_count_d;
  logic [2:0]         req_any;
  logic [1:0]         sel_kind;

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    pend_d      = pend_q;
    last_kind_d = last_kind_q;
    req_count_d = req_count_q;
    req_any     = kind_evt | pend_q;
    sel_kind    = req_any[0] ? KIND_COLD : (req_any[1] ? KIND_WARM : KIND_DEBUG);

    case (state_q)
      ST_IDLE: begin
        if (|req_any) begin
          state_d     = ST_PULSE;
          tmr_d       = '0;
          last_kind_d = sel_kind;
          if (req_count_q != {CNT_W{1'b1}}) req_count_d = req_count_q + 1'b1;
          // The issued kind is the highest one present. Clearing it and
          // everything below leaves nothing, and this also drops any
          // lower-priority events from this same cycle.
          pend_d      = '0;
        end
      end
      ST_PULSE: begin
        pend_d = pend_q | kind_evt;
        if (tmr_q == PULSE_LAST) begin
          state_d = ST_HOLDOFF;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_HOLDOFF: begin
        pend_d = pend_q | kind_evt;
        if (tmr_q == HOLD_LAST) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The outputs are decoded from next-state so they are registered but still
  // change on the same edge as the FSM. The async reset releases a request
  // line at once.
  logic cold_n_q, warm_n_q, debug_n_q, busy_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      pend_q      <= '0;
      last_kind_q <= '0;
      req_count_q <= '0;
      cold_n_q    <= 1'b1;
      warm_n_q    <= 1'b1;
      debug_n_q   <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      pend_q      <= pend_d;
      last_kind_q <= last_kind_d;
      req_count_q <= req_count_d;
      cold_n_q    <= !(state_d == ST_PULSE && last_kind_d == KIND_COLD);
      warm_n_q    <= !(state_d == ST_PULSE && last_kind_d == KIND_WARM);
      debug_n_q   <= !(state_d == ST_PULSE && last_kind_d == KIND_DEBUG);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  // -------------------------------------------------------------------------
  // Fabric reset: synchronise h2f_reset_n, assert at once, release late
  // -------------------------------------------------------------------------
  logic             h2f_s1_q, h2f_s2_q, fabric_rst_n_q;
  logic [REL_W-1:0] rel_cnt_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      h2f_s1_q       <= 1'b0;
      h2f_s2_q       <= 1'b0;
      rel_cnt_q      <= '0;
      fabric_rst_n_q <= 1'b0;
    end else begin
      h2f_s1_q <= h2f_reset_n;
      h2f_s2_q <= h2f_s1_q;
      if (!h2f_s2_q) begin
        rel_cnt_q      <= '0;
        fabric_rst_n_q <= 1'b0;
      end else if (!fabric_rst_n_q) begin
        if (rel_cnt_q == REL_LAST) fabric_rst_n_q <= 1'b1;
        else                       rel_cnt_q      <= rel_cnt_q + 1'b1;
      end
    end
  end

  assign f2h_cold_reset_req_n  = cold_n_q;
  assign f2h_warm_reset_req_n  = warm_n_q;
  assign f2h_debug_reset_req_n = debug_n_q;
  assign fabric_rst_n          = fabric_rst_n_q;
  assign busy                  = busy_q;
  assign last_kind             = last_kind_q;
  assign req_count             = req_count_q;

endmodule

// File: tb/tb_hps_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_hps_reset_seq
//   Directed bench for hps_reset_seq with small timing parameters.
//   A timeline model (run lengths, event delay line, pulse window arithmetic)
//   is compared against the DUT on every falling clock edge. Literal
//   edge-by-edge expectations pin down the model itself.
// ---------------------------------------------------------------------------
module tb_hps_reset_seq;

  localparam int NSRC = 4;
  localparam int DEB  = 4;
  localparam int PUL  = 3;
  localparam int HOLD = 5;
  localparam int REL  = 2;
  localparam int CW   = 2;
  localparam int CMAX = 3;

  logic            clk_clk       = 1'b0;
  logic            reset_reset_n = 1'b1;
  logic [NSRC-1:0] src_req       = '0;
  logic            h2f_reset_n   = 1'b1;
  logic            f2h_cold_reset_req_n;
  logic            f2h_warm_reset_req_n;
  logic            f2h_debug_reset_req_n;
  logic            fabric_rst_n;
  logic            busy;
  logic [1:0]      last_kind;
  logic [CW-1:0]   req_count;

  hps_reset_seq #(
    .NUM_SRC        (NSRC),
    .SRC_KIND       (8'b11_10_01_00),
    .DEBOUNCE_CYCLES(DEB),
    .PULSE_CYCLES   (PUL),
    .HOLDOFF_CYCLES (HOLD),
    .RELEASE_DELAY  (REL),
    .CNT_W          (CW)
  ) dut (
    .clk_clk              (clk_clk),
    .reset_reset_n        (reset_reset_n),
    .src_req              (src_req),
    .h2f_reset_n          (h2f_reset_n),
    .f2h_cold_reset_req_n (f2h_cold_reset_req_n),
    .f2h_warm_reset_req_n (f2h_warm_reset_req_n),
    .f2h_debug_reset_req_n(f2h_debug_reset_req_n),
    .fabric_rst_n         (fabric_rst_n),
    .busy                 (busy),
    .last_kind            (last_kind),
    .req_count            (req_count)
  );

  always #5 clk_clk = ~clk_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Timeline model
  // -------------------------------------------------------------------------
  int         kind_of [NSRC] = '{0, 1, 2, 3};
  int         hi_run  [NSRC];
  logic [2:0] dly0, dly1, dly2;
  logic [2:0] pend;
  int         tnow, ps, last_k, cnt, hr1, hr2;
  logic       exp_cold, exp_warm, exp_dbg, exp_busy, exp_fab;

  task automatic model_reset();
    for (int s = 0; s < NSRC; s++) hi_run[s] = 0;
    dly0 = '0; dly1 = '0; dly2 = '0; pend = '0;
    tnow = 0; ps = -1000; last_k = 0; cnt = 0; hr1 = 0; hr2 = 0;
    exp_cold = 1'b1; exp_warm = 1'b1; exp_dbg = 1'b1;
    exp_busy = 1'b0; exp_fab = 1'b0;
  endtask

  task automatic model_step();
    logic [2:0] ev, req;
    int run_now;
    bit in_pulse;
    tnow++;
    // An event whose D-th consecutive high sample lands on edge n is
    // arbitrated on edge n+3.
    ev   = dly2;
    dly2 = dly1;
    dly1 = dly0;
    dly0 = '0;
    for (int s = 0; s < NSRC; s++) begin
      if (src_req[s]) begin
        if (hi_run[s] <= DEB) hi_run[s]++;
      end else begin
        hi_run[s] = 0;
      end
      if (hi_run[s] == DEB && src_req[s] && kind_of[s] != 3) dly0[kind_of[s]] = 1'b1;
    end
    // The sequencer was idle before this edge once the last pulse and its
    // holdoff have fully elapsed.
    if (tnow >= ps + PUL + HOLD + 1) begin
      req = ev | pend;
      if (req != 3'b000) begin
        last_k = req[0] ? 0 : (req[1] ? 1 : 2);
        ps     = tnow;
        if (cnt < CMAX) cnt++;
        pend   = '0;
      end
    end else begin
      pend = pend | ev;
    end
    in_pulse = (tnow >= ps) && (tnow < ps + PUL);
    exp_cold = !(in_pulse && last_k == 0);
    exp_warm = !(in_pulse && last_k == 1);
    exp_dbg  = !(in_pulse && last_k == 2);
    exp_busy = (tnow < ps + PUL + HOLD);
    // Fabric reset follows the h2f sample run length two edges back.
    run_now = h2f_reset_n ? ((hr1 <= REL) ? hr1 + 1 : hr1) : 0;
    exp_fab = (hr2 >= REL);
    hr2 = hr1;
    hr1 = run_now;
  endtask

  initial begin : model_proc
    model_reset();
    forever begin
      @(posedge clk_clk or negedge reset_reset_n);
      if (!reset_reset_n) model_reset();
      else                model_step();
    end
  end

  initial begin : compare_proc
    #2;
    forever begin
      @(negedge clk_clk);
      check("cold_n",    f2h_cold_reset_req_n,  exp_cold);
      check("warm_n",    f2h_warm_reset_req_n,  exp_warm);
      check("debug_n",   f2h_debug_reset_req_n, exp_dbg);
      check("busy",      busy,                  exp_busy);
      check("fabric",    fabric_rst_n,          exp_fab);
      check("last_kind", last_kind,             last_k);
      check("req_count", req_count,             cnt);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic do_reset();
    @(negedge clk_clk);
    #1;
    reset_reset_n = 1'b0;
    src_req       = '0;
    h2f_reset_n   = 1'b1;
    repeat (3) @(negedge clk_clk);
    check("rst_cold",   f2h_cold_reset_req_n, 1);
    check("rst_fabric", fabric_rst_n,         0);
    check("rst_busy",   busy,                 0);
    check("rst_count",  req_count,            0);
    #1;
    reset_reset_n = 1'b1;
    repeat (6) @(negedge clk_clk);
  endtask

  task automatic wait_cold_low(input string name);
    int n = 0;
    while (f2h_cold_reset_req_n !== 1'b0 && n < 20) begin
      @(posedge clk_clk); #1; n++;
    end
    check(name, (n < 20), 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 30) begin
      @(posedge clk_clk); #1; n++;
    end
    check(name, (n < 30), 1);
  endtask

  int exp_sat [5] = '{1, 2, 3, 3, 3};

  initial begin : stim
    bit seen_cold, seen_warm, seen_dbg;
    #1 reset_reset_n = 1'b0;
    #20;

    // Single cold source held high: pulse on edge 7, three cycles wide.
    do_reset();
    check("fabric_up", fabric_rst_n, 1);
    src_req[0] = 1'b1;
    repeat (6) @(posedge clk_clk); #1;
    check("e037_edge6_cold", f2h_cold_reset_req_n, 1);
    @(posedge clk_clk); #1;
    check("e037_edge7_cold", f2h_cold_reset_req_n, 0);
    check("e037_edge7_busy", busy, 1);
    repeat (2) @(posedge clk_clk); #1;
    check("e037_edge9_cold", f2h_cold_reset_req_n, 0);
    @(posedge clk_clk); #1;
    check("e037_edge10_cold", f2h_cold_reset_req_n, 1);
    repeat (4) @(posedge clk_clk); #1;
    check("e037_edge14_busy", busy, 1);
    @(posedge clk_clk); #1;
    check("e037_edge15_busy", busy, 0);
    check("e037_last_kind", last_kind, 0);
    check("e037_count", req_count, 1);
    src_req = '0;

    // Short glitch on a cold source plus a disabled source: nothing issued.
    do_reset();
    src_req = 4'b1001;
    repeat (3) @(posedge clk_clk); #1;
    src_req[0] = 1'b0;
    seen_cold = 0; seen_warm = 0; seen_dbg = 0;
    repeat (25) begin
      @(posedge clk_clk); #1;
      if (!f2h_cold_reset_req_n || !f2h_warm_reset_req_n || !f2h_debug_reset_req_n) seen_cold = 1;
    end
    check("e038_no_request", seen_cold, 0);
    check("e038_count", req_count, 0);
    src_req = '0;

    // Warm and debug rising together: warm only.
    do_reset();
    src_req = 4'b0110;
    seen_warm = 0; seen_dbg = 0;
    repeat (30) begin
      @(posedge clk_clk); #1;
      if (!f2h_warm_reset_req_n)  seen_warm = 1;
      if (!f2h_debug_reset_req_n) seen_dbg  = 1;
    end
    check("e039_warm_seen", seen_warm, 1);
    check("e039_debug_seen", seen_dbg, 0);
    check("e039_last_kind", last_kind, 1);
    check("e039_count", req_count, 1);
    src_req = '0;

    // A cold event during a warm pulse is held pending and issued afterwards.
    do_reset();
    src_req[1] = 1'b1;
    repeat (2) @(posedge clk_clk); #1;
    src_req[0] = 1'b1;
    repeat (5) @(posedge clk_clk); #1;
    check("e040_edge7_warm", f2h_warm_reset_req_n, 0);
    check("e040_edge7_cold", f2h_cold_reset_req_n, 1);
    repeat (8) @(posedge clk_clk); #1;
    check("e040_edge15_busy", busy, 0);
    @(posedge clk_clk); #1;
    check("e040_edge16_cold", f2h_cold_reset_req_n, 0);
    check("e040_last_kind", last_kind, 0);
    check("e040_count", req_count, 2);
    repeat (2) @(posedge clk_clk); #1;
    check("e040_edge18_cold", f2h_cold_reset_req_n, 0);
    @(posedge clk_clk); #1;
    check("e040_edge19_cold", f2h_cold_reset_req_n, 1);
    src_req = '0;
    wait_idle("e040_idle");

    // Five cold pulses: the 2-bit counter saturates at 3.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      src_req[0] = 1'b1;
      wait_cold_low("e041_wait_pulse");
      check("e041_count", req_count, exp_sat[i]);
      src_req[0] = 1'b0;
      wait_idle("e041_idle");
    end

    // Fabric reset: assert after three edges, release two after sync-high.
    do_reset();
    @(negedge clk_clk);
    h2f_reset_n = 1'b0;
    repeat (2) @(posedge clk_clk); #1;
    check("e042_fab_edge2_low", fabric_rst_n, 1);
    @(posedge clk_clk); #1;
    check("e042_fab_edge3_low", fabric_rst_n, 0);
    repeat (3) @(negedge clk_clk);
    h2f_reset_n = 1'b1;
    repeat (3) @(posedge clk_clk); #1;
    check("e042_fab_edge3_high", fabric_rst_n, 0);
    @(posedge clk_clk); #1;
    check("e042_fab_edge4_high", fabric_rst_n, 1);
    @(negedge clk_clk);
    h2f_reset_n = 1'b0;
    @(negedge clk_clk);
    h2f_reset_n = 1'b1;
    repeat (8) @(negedge clk_clk);

    // Reset asserted in the middle of a cold pulse.
    src_req[0] = 1'b1;
    wait_cold_low("e042_wait_pulse");
    #2;
    reset_reset_n = 1'b0;
    src_req       = '0;
    #1;
    check("e042_rst_cold",   f2h_cold_reset_req_n, 1);
    check("e042_rst_busy",   busy,                 0);
    check("e042_rst_fabric", fabric_rst_n,         0);
    check("e042_rst_count",  req_count,            0);
    check("e042_rst_kind",   last_kind,            0);
    repeat (3) @(negedge clk_clk);
    #1 reset_reset_n = 1'b1;
    seen_cold = 0;
    repeat (20) begin
      @(posedge clk_clk); #1;
      if (!f2h_cold_reset_req_n) seen_cold = 1;
    end
    check("e042_no_resume", seen_cold, 0);
    check("e042_count_after", req_count, 0);

    repeat (3) @(negedge clk_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
